// File: rtl/telem_pkg.sv
// telem_pkg: shared constants, types and frame-assembly helpers for telemetry_tx.
package telem_pkg;

    // Frame layout
    localparam logic [7:0] HDR         = 8'hA5;
    localparam int         FRAME_BYTES = 9;
    localparam logic [3:0] LAST_BYTE   = 4'(FRAME_BYTES - 1);

    // Status flag positions inside byte 3 (bit 4 is reserved, always 0)
    localparam int B3_PWR_UP   = 7;
    localparam int B3_EN_STEER = 6;
    localparam int B3_TOO_FAST = 5;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } frame_state_t;

    // Everything captured at a trigger; frame bytes are derived only from this
    typedef struct packed {
        logic [15:0] ptch;
        logic [11:0] batt;
        logic [11:0] lft_spd;
        logic [11:0] rght_spd;
        logic        pwr_up;
        logic        en_steer;
        logic        too_fast;
    } snapshot_t;

    // Byte 3: status flags in the upper nibble, battery bits 11:8 in the lower nibble
    function automatic logic [7:0] flag_byte(input snapshot_t s);
        logic [7:0] b;
        b              = {4'b0000, s.batt[11:8]};
        b[B3_PWR_UP]   = s.pwr_up;
        b[B3_EN_STEER] = s.en_steer;
        b[B3_TOO_FAST] = s.too_fast;
        return b;
    endfunction

    // Bytes 0..7 of the frame (header plus payload)
    function automatic logic [7:0] payload_byte(input snapshot_t s, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = HDR;
            4'd1:    b = s.ptch[15:8];
            4'd2:    b = s.ptch[7:0];
            4'd3:    b = flag_byte(s);
            4'd4:    b = s.batt[7:0];
            4'd5:    b = s.lft_spd[11:4];
            4'd6:    b = {s.lft_spd[3:0], s.rght_spd[11:8]};
            4'd7:    b = s.rght_spd[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Checksum covers the payload only (bytes 1..7), not the header
    function automatic logic [7:0] checksum(input snapshot_t s);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 1; i < FRAME_BYTES - 1; i++) begin
            c = c ^ payload_byte(s, 4'(i));
        end
        return c;
    endfunction

    // Full byte mux: payload bytes, then the checksum as the final byte
    function automatic logic [7:0] frame_byte(input snapshot_t s, input logic [3:0] idx);
        logic [7:0] b;
        if (idx == LAST_BYTE) begin
            b = checksum(s);
        end else begin
            b = payload_byte(s, idx);
        end
        return b;
    endfunction

endpackage

// File: rtl/telem_uart_tx.sv
// telem_uart_tx: 8N1 UART transmitter, LSB first, one byte per trmt pulse.
// tx_done is asserted during the final cycle of the stop bit so the next byte
// can follow with a single idle-high cycle.
module telem_uart_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam int BAUD_W = $clog2(BAUD_DIV);

    logic              active;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_cnt;
    logic [8:0]        shift;
    logic              bit_end;

    // Last cycle of the current bit period
    assign bit_end = active && (baud_cnt == BAUD_W'(BAUD_DIV - 1));
    // Bit 9 is the stop bit; its last cycle ends the byte
    assign tx_done = bit_end && (bit_cnt == 4'd9);

    // Bit sequencing: start bit on load, then shift out data LSB first, stop bit last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
            shift    <= '1;
            TX       <= 1'b1;
        end else if (trmt && !active) begin
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
            shift    <= {1'b1, tx_data};
            TX       <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active  <= 1'b0;
                    bit_cnt <= 4'd0;
                    TX      <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    TX      <= shift[0];
                    shift   <= {1'b1, shift[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end
        end
    end

endmodule

// File: rtl/telemetry_tx.sv
// telemetry_tx: decimates inertial-update strobes, snapshots telemetry fields
// and sends them as a 9-byte checksummed frame over an 8N1 UART.
// Valid/ready contract with the UART: trmt is a one-cycle request honoured only
// while the UART is idle; tx_done marks the last cycle of the stop bit.
module telemetry_tx
    import telem_pkg::*;
#(
    parameter int BAUD_DIV = 2604,   // clocks per UART bit, at least 4
    parameter int DECIM    = 16      // qualified vld pulses per frame, at least 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic signed [15:0] ptch,
    input  logic        [11:0] batt,
    input  logic signed [11:0] lft_spd,
    input  logic signed [11:0] rght_spd,
    input  logic               pwr_up,
    input  logic               en_steer,
    input  logic               too_fast,
    output logic               TX,
    output logic               busy,
    output logic        [7:0]  drop_cnt
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [CNT_W-1:0] dec_cnt;
    logic             trigger;
    frame_state_t     state;
    logic [3:0]       byte_idx;
    logic             trmt;
    logic             tx_done;
    logic [7:0]       tx_data;
    snapshot_t        snap;

    // A trigger is the DECIM-th qualified strobe since the counter last wrapped
    assign trigger = vld && pwr_up && (dec_cnt == CNT_W'(DECIM - 1));

    // Decimation counter; pwr_up low holds it cleared so no triggers occur
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt <= '0;
        end else if (!pwr_up) begin
            dec_cnt <= '0;
        end else if (vld) begin
            if (trigger) begin
                dec_cnt <= '0;
            end else begin
                dec_cnt <= dec_cnt + CNT_W'(1);
            end
        end
    end

    // Byte mux reads only the snapshot, so live inputs never reach bytes in flight
    assign tx_data = frame_byte(snap, byte_idx);

    // Frame sequencer: snapshot on an idle trigger, then LOAD/WAIT once per byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            byte_idx <= 4'd0;
            trmt     <= 1'b0;
            busy     <= 1'b0;
            snap     <= '0;
        end else begin
            trmt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        snap.ptch     <= ptch;
                        snap.batt     <= batt;
                        snap.lft_spd  <= lft_spd;
                        snap.rght_spd <= rght_spd;
                        snap.pwr_up   <= pwr_up;
                        snap.en_steer <= en_steer;
                        snap.too_fast <= too_fast;
                        byte_idx      <= 4'd0;
                        trmt          <= 1'b1;
                        state         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // UART latches tx_data this cycle; busy rises with the start bit
                    busy  <= 1'b1;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (byte_idx == LAST_BYTE) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            trmt     <= 1'b1;
                            state    <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Count triggers that arrive while a frame is already underway, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'h00;
        end else if (trigger && (state != ST_IDLE) && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end

    telem_uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done)
    );

endmodule

// File: tb/tb_telemetry_tx.sv
// tb_telemetry_tx: checks telemetry_tx framing, bit timing, decimation,
// drop counting and reset behaviour against a byte-level reference model.
module tb_telemetry_tx;

    localparam int NBYTES = 9;
    localparam int BD     = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               vld1, vld4;
    logic signed [15:0] ptch;
    logic        [11:0] batt;
    logic signed [11:0] lft_spd, rght_spd;
    logic               pwr_up, en_steer, too_fast;
    logic               tx1, busy1, tx4, busy4;
    logic [7:0]         drop1, drop4;

    telemetry_tx #(.BAUD_DIV(BD), .DECIM(1)) dut (
        .clk(clk), .rst_n(rst_n), .vld(vld1), .ptch(ptch), .batt(batt),
        .lft_spd(lft_spd), .rght_spd(rght_spd), .pwr_up(pwr_up),
        .en_steer(en_steer), .too_fast(too_fast),
        .TX(tx1), .busy(busy1), .drop_cnt(drop1)
    );

    telemetry_tx #(.BAUD_DIV(BD), .DECIM(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .vld(vld4), .ptch(ptch), .batt(batt),
        .lft_spd(lft_spd), .rght_spd(rght_spd), .pwr_up(pwr_up),
        .en_steer(en_steer), .too_fast(too_fast),
        .TX(tx4), .busy(busy4), .drop_cnt(drop4)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int checks = 0;
    int errors = 0;
    int exp_drop = 0;
    int pend4 = 0;
    int exp_frames4 = 0;

    // Monitors for the DECIM=4 instance: frames started and TX low cycles
    int   frames4 = 0;
    int   tx4_low = 0;
    logic busy4_q = 1'b0;
    always @(posedge clk) begin
        if (busy4 && !busy4_q) frames4 <= frames4 + 1;
        busy4_q <= busy4;
    end
    always @(negedge clk) begin
        if (tx4 === 1'b0) tx4_low <= tx4_low + 1;
    end

    // ---------------- reference model ----------------
    // Frame = header, then the fields laid end to end, then XOR of payload bytes
    task automatic push_expected();
        logic [63:0] payload;
        logic [7:0]  b;
        logic [7:0]  cs;
        payload = {8'hA5, ptch, pwr_up, en_steer, too_fast, 1'b0, batt, lft_spd, rght_spd};
        cs = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b = payload[63 - 8*i -: 8];
            exp_q.push_back(b);
            if (i > 0) cs = cs ^ b;
        end
        exp_q.push_back(cs);
    endtask

    function automatic logic [7:0] pop_got();
        if (got_q.size() == 0) return 8'hxx;
        return got_q.pop_front();
    endfunction

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() == 0) return 8'h00;
        return exp_q.pop_front();
    endfunction

    function automatic int sat_add(input int a, input int n);
        return (a + n > 255) ? 255 : a + n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic randomize_inputs();
        ptch     = 16'($urandom);
        batt     = 12'($urandom);
        lft_spd  = 12'($urandom);
        rght_spd = 12'($urandom);
        en_steer = 1'($urandom);
        too_fast = 1'($urandom);
    endtask

    // Called just after a rising edge; vld1 is high for exactly one cycle
    task automatic fire1();
        vld1 = 1'b1;
        @(posedge clk); #1;
        vld1 = 1'b0;
    endtask

    task automatic pulse4();
        vld4 = 1'b1;
        @(posedge clk); #1;
        vld4 = 1'b0;
        if (pwr_up) begin
            pend4++;
            if (pend4 == 4) begin
                pend4 = 0;
                exp_frames4++;
            end
        end
    endtask

    // Cycle-accurate receiver for dut TX: every bit must hold for exactly BD cycles,
    // at most one idle cycle between bytes, busy must drop right after the last stop bit
    task automatic rx_frame(output int bad, output int found);
        logic [7:0] b;
        logic       lvl;
        int         t;
        bad = 0; found = 0; t = 0; b = 8'h00;
        @(negedge clk);
        while (tx1 !== 1'b0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (tx1 !== 1'b0) return;
        found = 1;
        for (int n = 0; n < NBYTES; n++) begin
            if (n > 0 && tx1 === 1'b1) @(negedge clk);
            for (int k = 0; k < 10; k++) begin
                lvl = tx1;
                for (int c = 0; c < BD; c++) begin
                    if (tx1 !== lvl) bad++;
                    if (n == NBYTES - 1 && k == 9 && c == BD - 1 && busy1 !== 1'b1) bad++;
                    @(negedge clk);
                end
                if (k == 0 && lvl !== 1'b0) bad++;
                if (k == 9 && lvl !== 1'b1) bad++;
                if (k >= 1 && k <= 8) b[k-1] = lvl;
            end
            got_q.push_back(b);
        end
        if (busy1 !== 1'b0) bad++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; vld1 = 1'b0; vld4 = 1'b0;
        ptch = '0; batt = '0; lft_spd = '0; rght_spd = '0;
        pwr_up = 1'b0; en_steer = 1'b0; too_fast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx1 !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b expected 1", tx1); end
        checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
        checks++; if (drop1 !== 8'h00) begin errors++; $display("FAIL reset_drop: got %02h expected 00", drop1); end
        checks++; if (tx4 !== 1'b1)    begin errors++; $display("FAIL reset_tx4: got %b expected 1", tx4); end
        checks++; if (busy4 !== 1'b0)  begin errors++; $display("FAIL reset_busy4: got %b expected 0", busy4); end
        checks++; if (drop4 !== 8'h00) begin errors++; $display("FAIL reset_drop4: got %02h expected 00", drop4); end
        rst_n = 1'b1;
        pwr_up = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: tx=%b busy=%b expected tx=1 busy=0", tx1, busy1);
        end
    endtask

    task automatic test_known_frame();
        logic [7:0] known [NBYTES];
        logic [7:0] g;
        int bad, found;
        known = '{8'hA5, 8'h12, 8'h34, 8'hCA, 8'hBC, 8'h12, 8'h3F, 8'hED, 8'h00};
        for (int i = 1; i < NBYTES - 1; i++) known[NBYTES-1] = known[NBYTES-1] ^ known[i];
        pwr_up = 1'b1; en_steer = 1'b1; too_fast = 1'b0;
        ptch = 16'h1234; batt = 12'hABC; lft_spd = 12'h123; rght_spd = 12'hFED;
        fire1();
        // one cycle after the trigger cycle: nothing visible yet
        checks++; if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++; $display("FAIL start_n1: tx=%b busy=%b expected tx=1 busy=0", tx1, busy1);
        end
        @(posedge clk); #1;
        checks++; if (tx1 !== 1'b0) begin errors++; $display("FAIL start_bit_n2: got %b expected 0", tx1); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL busy_n2: got %b expected 1", busy1); end
        rx_frame(bad, found);
        checks++; if (found != 1) begin errors++; $display("FAIL known_frame_seen: got %0d expected 1", found); end
        checks++; if (bad != 0) begin errors++; $display("FAIL known_bit_timing: got %0d faults expected 0", bad); end
        for (int i = 0; i < NBYTES; i++) begin
            g = pop_got();
            checks++;
            if (g !== known[i]) begin errors++; $display("FAIL known_byte%0d: got %02h expected %02h", i, g, known[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_frames();
        int bad, found, gap, mid;
        logic [7:0] g, e;
        for (int r = 0; r < 4; r++) begin
            randomize_inputs();
            gap = $urandom_range(1, 20);
            mid = $urandom_range(50, 650);
            repeat (gap) @(posedge clk);
            #1;
            fork
                begin
                    push_expected();
                    fire1();
                    repeat (mid) @(posedge clk);
                    #1;
                    randomize_inputs();
                end
                rx_frame(bad, found);
            join
            @(posedge clk); #1;
            checks++; if (found != 1 || bad != 0) begin
                errors++; $display("FAIL rand%0d_frame: found=%0d faults=%0d expected 1 and 0", r, found, bad);
            end
            for (int i = 0; i < NBYTES; i++) begin
                g = pop_got(); e = pop_exp();
                checks++;
                if (g !== e) begin errors++; $display("FAIL rand%0d_byte%0d: got %02h expected %02h", r, i, g, e); end
            end
            checks++; if (drop1 !== 8'(exp_drop)) begin
                errors++; $display("FAIL rand%0d_drop: got %0d expected %0d", r, drop1, exp_drop);
            end
        end
    endtask

    task automatic test_drops();
        int bad, found;
        logic [7:0] g, e;
        // Trigger every 100 cycles: the frame outlasts seven later triggers
        randomize_inputs();
        fork
            begin
                push_expected();
                fire1();
                for (int k = 1; k <= 7; k++) begin
                    randomize_inputs();
                    repeat (98) @(posedge clk);
                    #1;
                    fire1();
                    exp_drop = sat_add(exp_drop, 1);
                end
            end
            rx_frame(bad, found);
        join
        @(posedge clk); #1;
        checks++; if (found != 1 || bad != 0) begin
            errors++; $display("FAIL drop_frame: found=%0d faults=%0d expected 1 and 0", found, bad);
        end
        for (int i = 0; i < NBYTES; i++) begin
            g = pop_got(); e = pop_exp();
            checks++;
            if (g !== e) begin errors++; $display("FAIL drop_byte%0d: got %02h expected %02h", i, g, e); end
        end
        checks++; if (drop1 !== 8'(exp_drop)) begin
            errors++; $display("FAIL drop_count: got %0d expected %0d", drop1, exp_drop);
        end
        // 300 back-to-back triggers inside one frame saturate the counter
        randomize_inputs();
        fork
            begin
                push_expected();
                fire1();
                @(posedge clk); #1;
                vld1 = 1'b1;
                repeat (100) @(posedge clk);
                #1;
                exp_drop = sat_add(exp_drop, 100);
                checks++; if (drop1 !== 8'(exp_drop)) begin
                    errors++; $display("FAIL drop_partial: got %0d expected %0d", drop1, exp_drop);
                end
                randomize_inputs();
                repeat (200) @(posedge clk);
                #1;
                vld1 = 1'b0;
                exp_drop = sat_add(exp_drop, 200);
                checks++; if (drop1 !== 8'(exp_drop)) begin
                    errors++; $display("FAIL drop_saturate: got %0d expected %0d", drop1, exp_drop);
                end
            end
            rx_frame(bad, found);
        join
        @(posedge clk); #1;
        checks++; if (found != 1 || bad != 0) begin
            errors++; $display("FAIL sat_frame: found=%0d faults=%0d expected 1 and 0", found, bad);
        end
        for (int i = 0; i < NBYTES; i++) begin
            g = pop_got(); e = pop_exp();
            checks++;
            if (g !== e) begin errors++; $display("FAIL sat_byte%0d: got %02h expected %02h", i, g, e); end
        end
    endtask

    task automatic test_decim();
        int f0, l0;
        pwr_up = 1'b1;
        f0 = frames4; exp_frames4 = 0; pend4 = 0;
        for (int p = 0; p < 12; p++) begin
            pulse4();
            repeat (199) @(posedge clk);
            #1;
        end
        repeat (800) @(posedge clk);
        #1;
        checks++; if (frames4 - f0 != exp_frames4) begin
            errors++; $display("FAIL decim_frames: got %0d expected %0d", frames4 - f0, exp_frames4);
        end
        checks++; if (drop4 !== 8'h00) begin errors++; $display("FAIL decim_drop: got %0d expected 0", drop4); end
        // pwr_up low: strobes ignored, line stays idle
        pwr_up = 1'b0; pend4 = 0;
        f0 = frames4; l0 = tx4_low; exp_frames4 = 0;
        for (int p = 0; p < 12; p++) begin
            pulse4();
            repeat (4) @(posedge clk);
            #1;
        end
        repeat (100) @(posedge clk);
        #1;
        checks++; if (frames4 - f0 != exp_frames4) begin
            errors++; $display("FAIL nopwr_frames: got %0d expected %0d", frames4 - f0, exp_frames4);
        end
        checks++; if (tx4_low != l0) begin
            errors++; $display("FAIL nopwr_tx_idle: got %0d low cycles expected 0", tx4_low - l0);
        end
        // Dropping pwr_up discards a partial count
        pwr_up = 1'b1;
        f0 = frames4; exp_frames4 = 0;
        for (int p = 0; p < 3; p++) begin pulse4(); repeat (2) @(posedge clk); #1; end
        pwr_up = 1'b0; pend4 = 0;
        repeat (2) @(posedge clk);
        #1;
        pwr_up = 1'b1;
        pulse4();
        repeat (10) @(posedge clk);
        #1;
        checks++; if (frames4 - f0 != exp_frames4) begin
            errors++; $display("FAIL decim_cleared: got %0d expected %0d", frames4 - f0, exp_frames4);
        end
        for (int p = 0; p < 3; p++) begin pulse4(); repeat (2) @(posedge clk); #1; end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (frames4 - f0 != exp_frames4) begin
            errors++; $display("FAIL decim_after_clear: got %0d expected %0d", frames4 - f0, exp_frames4);
        end
        repeat (800) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int bad_a, found_a, bad_b, found_b, t;
        logic seen_high, fell;
        logic [7:0] g, e;
        randomize_inputs();
        seen_high = 1'b0; fell = 1'b0; t = 0;
        fork
            begin
                push_expected();
                fire1();
                while (!fell && t < 2000) begin
                    @(posedge clk); #1;
                    t++;
                    if (busy1 === 1'b1) seen_high = 1'b1;
                    else if (seen_high) fell = 1'b1;
                end
                if (fell) begin
                    // the very cycle busy falls: this trigger must start a new frame
                    randomize_inputs();
                    push_expected();
                    fire1();
                end
            end
            begin
                rx_frame(bad_a, found_a);
                rx_frame(bad_b, found_b);
            end
        join
        @(posedge clk); #1;
        checks++; if (!fell) begin errors++; $display("FAIL b2b_busy_fall: got none expected a falling edge"); end
        checks++; if (found_a != 1 || bad_a != 0 || found_b != 1 || bad_b != 0) begin
            errors++; $display("FAIL b2b_frames: found=%0d/%0d faults=%0d/%0d expected 1/1 and 0/0",
                               found_a, found_b, bad_a, bad_b);
        end
        for (int i = 0; i < 2 * NBYTES; i++) begin
            g = pop_got(); e = pop_exp();
            checks++;
            if (g !== e) begin errors++; $display("FAIL b2b_byte%0d: got %02h expected %02h", i, g, e); end
        end
        checks++; if (drop1 !== 8'(exp_drop)) begin
            errors++; $display("FAIL b2b_drop: got %0d expected %0d", drop1, exp_drop);
        end
    endtask

    task automatic test_reset_mid();
        int bad, found, lows;
        logic [7:0] g, e;
        randomize_inputs();
        fire1();
        repeat (1 + 4 * (10 * BD + 1) + 20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (tx1 !== 1'b1)    begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx1); end
        checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy1); end
        checks++; if (drop1 !== 8'h00) begin errors++; $display("FAIL rstmid_drop: got %0d expected 0", drop1); end
        exp_drop = 0; pend4 = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        lows = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL rstmid_no_resume: got %0d active cycles expected 0", lows); end
        @(posedge clk); #1;
        randomize_inputs();
        fork
            begin
                push_expected();
                fire1();
            end
            rx_frame(bad, found);
        join
        @(posedge clk); #1;
        checks++; if (found != 1 || bad != 0) begin
            errors++; $display("FAIL rstmid_frame: found=%0d faults=%0d expected 1 and 0", found, bad);
        end
        for (int i = 0; i < NBYTES; i++) begin
            g = pop_got(); e = pop_exp();
            checks++;
            if (g !== e) begin errors++; $display("FAIL rstmid_byte%0d: got %02h expected %02h", i, g, e); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_known_frame();
        test_random_frames();
        test_drops();
        test_decim();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
